// File: rtl/fc_ctrl_pkg.sv
// fc_ctrl_pkg: shared types for the FC input buffer sequencer.
// State encoding and a width helper.
package fc_ctrl_pkg;

  typedef enum logic [1:0] {
    LOAD,
    STREAM,
    SHIFT,
    DONE
  } state_t;

  function automatic int clog2p1(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/fc_ibuf_ctrl_if.sv
// fc_ibuf_ctrl_if: load and stream handshakes plus buffer controls.
// master = sequencer, slave = environment (prev layer, buffer, xbar).
interface fc_ibuf_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int BIT_W  = 4
);
  logic              i_in_valid;
  logic              o_in_ready;
  logic              o_we;
  logic              o_se;
  logic [ADDR_W-1:0] o_ibuf_addr;
  logic              o_xbar_valid;
  logic              i_xbar_ready;
  logic [BIT_W-1:0]  o_bit_idx;
  logic              o_last_bit;
  logic              o_done;

  modport master (
    input  i_in_valid, i_xbar_ready,
    output o_in_ready, o_we, o_se, o_ibuf_addr,
    output o_xbar_valid, o_bit_idx, o_last_bit, o_done
  );

  modport slave (
    output i_in_valid, i_xbar_ready,
    input  o_in_ready, o_we, o_se, o_ibuf_addr,
    input  o_xbar_valid, o_bit_idx, o_last_bit, o_done
  );
endinterface

// File: rtl/wrap_cnt.sv
// wrap_cnt: counter that wraps to zero at TERM.
// Synchronous clear has priority over enable.
module wrap_cnt #(
  parameter int W    = 4,
  parameter int TERM = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         term
);
  localparam logic [W-1:0] TV = W'(TERM);

  assign term = (cnt == TV);

  // count up, wrap at terminal value
  always_ff @(posedge clk) begin
    if (!rst_n || clr) cnt <= '0;
    else if (en) cnt <= term ? '0 : cnt + W'(1);
  end
endmodule

// File: rtl/fc_ibuf_ctrl.sv
// fc_ibuf_ctrl: loads FIFO_LENGTH words, then streams the buffer
// bit-serially, LSB plane first, pulsing shift between planes.
module fc_ibuf_ctrl
  import fc_ctrl_pkg::*;
#(
  parameter int DATA_SIZE   = 8,
  parameter int FIFO_LENGTH = 16,
  parameter int NUM_ADDR    = 8,
  parameter int ADDR_W      = clog2p1(NUM_ADDR),
  parameter int BIT_W       = clog2p1(DATA_SIZE)
) (
  input logic           clk,
  input logic           rst_n,
  fc_ibuf_ctrl_if.master bus
);
  localparam int LOAD_W = clog2p1(FIFO_LENGTH);

  state_t state, state_nx;

  logic              we, hs;
  logic              load_term, addr_term, bit_term;
  logic [LOAD_W-1:0] unused_load_cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [BIT_W-1:0]  bit_cnt;

  assign we = (state == LOAD) & bus.i_in_valid;
  assign hs = (state == STREAM) & bus.i_xbar_ready;

  wrap_cnt #(.W(LOAD_W), .TERM(FIFO_LENGTH-1)) u_load (
    .clk(clk), .rst_n(rst_n),
    .clr(state == DONE), .en(we),
    .cnt(unused_load_cnt), .term(load_term)
  );

  wrap_cnt #(.W(ADDR_W), .TERM(NUM_ADDR-1)) u_addr (
    .clk(clk), .rst_n(rst_n),
    .clr(state == DONE), .en(hs),
    .cnt(addr_cnt), .term(addr_term)
  );

  wrap_cnt #(.W(BIT_W), .TERM(DATA_SIZE-1)) u_bit (
    .clk(clk), .rst_n(rst_n),
    .clr(state == DONE), .en(state == SHIFT),
    .cnt(bit_cnt), .term(bit_term)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOAD;
    else state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD:   if (we && load_term) state_nx = STREAM;
      STREAM: if (hs && addr_term)
                state_nx = bit_term ? DONE : SHIFT;
      SHIFT:  state_nx = STREAM;
      DONE:   state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  assign bus.o_in_ready   = (state == LOAD);
  assign bus.o_we         = we;
  assign bus.o_se         = (state == SHIFT);
  assign bus.o_xbar_valid = (state == STREAM);
  assign bus.o_ibuf_addr  = addr_cnt;
  assign bus.o_bit_idx    = bit_cnt;
  assign bus.o_last_bit   = (state == STREAM) & bit_term;
  assign bus.o_done       = (state == DONE);
endmodule

// File: tb/tb_fc_ibuf_ctrl.sv
// tb_fc_ibuf_ctrl: scoreboard bench for the FC input buffer
// sequencer, default build plus a DATA_SIZE=1/NUM_ADDR=1 build.
module tb_fc_ibuf_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fc_ibuf_ctrl_if #(.ADDR_W(4), .BIT_W(4)) bus ();
  fc_ibuf_ctrl_if #(.ADDR_W(1), .BIT_W(1)) bus2 ();

  fc_ibuf_ctrl #(
    .DATA_SIZE(8), .FIFO_LENGTH(16), .NUM_ADDR(8),
    .ADDR_W(4), .BIT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );

  fc_ibuf_ctrl #(
    .DATA_SIZE(1), .FIFO_LENGTH(16), .NUM_ADDR(1),
    .ADDR_W(1), .BIT_W(1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.master)
  );

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] addr;
    logic [3:0] bidx;
    logic       last;
  } ev_t;

  ev_t q1[$];
  ev_t q2[$];
  int  compared = 0;
  int  mismatched = 0;
  int  cyc = 0;
  int  t0 = 0;
  int  t_done = 0;
  bit  mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(input logic [1:0] k, input logic [3:0] a,
                             input logic [3:0] b, input logic l);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.bidx = b;
    e.last = l;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic pop_cmp(input int which, input ev_t got);
    ev_t e;
    bit empty;
    compared++;
    empty = (which == 1) ? (q1.size() == 0) : (q2.size() == 0);
    if (empty) begin
      mismatched++;
      $display("FAIL ev%0d unexpected: kind=%0d addr=%0d bit=%0d last=%0b",
               which, got.kind, got.addr, got.bidx, got.last);
    end else begin
      if (which == 1) e = q1.pop_front();
      else e = q2.pop_front();
      if (got !== e) begin
        mismatched++;
        $display("FAIL ev%0d: got k=%0d a=%0d b=%0d l=%0b expected k=%0d a=%0d b=%0d l=%0b",
                 which, got.kind, got.addr, got.bidx, got.last,
                 e.kind, e.addr, e.bidx, e.last);
      end
    end
  endtask

  // monitor: every observed event is matched against the queues
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.o_we) pop_cmp(1, mk(2'd0, 4'd0, 4'd0, 1'b0));
      if (bus.o_xbar_valid && bus.i_xbar_ready)
        pop_cmp(1, mk(2'd1, bus.o_ibuf_addr, bus.o_bit_idx, bus.o_last_bit));
      if (bus.o_se) pop_cmp(1, mk(2'd2, 4'd0, 4'd0, 1'b0));
      if (bus.o_done) begin
        pop_cmp(1, mk(2'd3, 4'd0, 4'd0, 1'b0));
        t_done = cyc;
      end
      check("we_se_excl", {31'd0, bus.o_we & bus.o_se}, 0);
      if (bus2.o_we) pop_cmp(2, mk(2'd0, 4'd0, 4'd0, 1'b0));
      if (bus2.o_xbar_valid && bus2.i_xbar_ready)
        pop_cmp(2, mk(2'd1, {3'd0, bus2.o_ibuf_addr},
                      {3'd0, bus2.o_bit_idx}, bus2.o_last_bit));
      if (bus2.o_se) pop_cmp(2, mk(2'd2, 4'd0, 4'd0, 1'b0));
      if (bus2.o_done) pop_cmp(2, mk(2'd3, 4'd0, 4'd0, 1'b0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int which, input bit toggle);
    int n;
    int i;
    logic v;
    n = 0;
    i = 0;
    while (n < 16) begin
      v = toggle ? logic'(i % 2 == 0) : 1'b1;
      if (which == 1) bus.i_in_valid = v;
      else bus2.i_in_valid = v;
      if (v) begin
        if (n == 0) t0 = cyc;
        if (which == 1) q1.push_back(mk(2'd0, 4'd0, 4'd0, 1'b0));
        else q2.push_back(mk(2'd0, 4'd0, 4'd0, 1'b0));
      end
      @(negedge clk);
      if (which == 1) begin
        check("load_we", {31'd0, bus.o_we}, {31'd0, v});
        check("load_rdy", {31'd0, bus.o_in_ready}, 1);
      end else begin
        check("load_we2", {31'd0, bus2.o_we}, {31'd0, v});
        check("load_rdy2", {31'd0, bus2.o_in_ready}, 1);
      end
      tick();
      if (v) n++;
      i++;
    end
    bus.i_in_valid = 1'b0;
    bus2.i_in_valid = 1'b0;
  endtask

  task automatic stream(input int sa, input int sb,
                        input int ra, input int rb);
    bus.i_xbar_ready = 1'b1;
    check("first_stream_rdy", {31'd0, bus.o_in_ready}, 0);
    for (int b = 0; b < 8; b++) begin
      for (int a = 0; a < 8; a++) begin
        if (a == sa && b == sb) begin
          bus.i_xbar_ready = 1'b0;
          repeat (3) begin
            @(negedge clk);
            check("stall_addr", {28'd0, bus.o_ibuf_addr}, a);
            check("stall_valid", {31'd0, bus.o_xbar_valid}, 1);
            check("stall_se", {31'd0, bus.o_se}, 0);
            tick();
          end
          bus.i_xbar_ready = 1'b1;
        end
        q1.push_back(mk(2'd1, 4'(a), 4'(b), b == 7));
        if (a == ra && b == rb) begin
          rst_n = 1'b0;
          tick();
          check("rst_we", {31'd0, bus.o_we}, 0);
          check("rst_se", {31'd0, bus.o_se}, 0);
          check("rst_xvalid", {31'd0, bus.o_xbar_valid}, 0);
          check("rst_done", {31'd0, bus.o_done}, 0);
          check("rst_addr", {28'd0, bus.o_ibuf_addr}, 0);
          check("rst_bit", {28'd0, bus.o_bit_idx}, 0);
          check("rst_last", {31'd0, bus.o_last_bit}, 0);
          check("rst_rdy", {31'd0, bus.o_in_ready}, 1);
          rst_n = 1'b1;
          return;
        end
        tick();
        if (a == 7 && b < 7) begin
          q1.push_back(mk(2'd2, 4'd0, 4'd0, 1'b0));
          tick();
        end
      end
    end
    q1.push_back(mk(2'd3, 4'd0, 4'd0, 1'b0));
    tick();
    check("back_to_load", {31'd0, bus.o_in_ready}, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_in_valid = 1'b0;
    bus.i_xbar_ready = 1'b0;
    bus2.i_in_valid = 1'b0;
    bus2.i_xbar_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    check("init_we", {31'd0, bus.o_we}, 0);
    check("init_se", {31'd0, bus.o_se}, 0);
    check("init_xvalid", {31'd0, bus.o_xbar_valid}, 0);
    check("init_done", {31'd0, bus.o_done}, 0);
    check("init_addr", {28'd0, bus.o_ibuf_addr}, 0);
    check("init_bit", {28'd0, bus.o_bit_idx}, 0);
    check("init_last", {31'd0, bus.o_last_bit}, 0);
    check("init2_xvalid", {31'd0, bus2.o_xbar_valid}, 0);
    rst_n = 1'b1;
    tick();
    check("init_rdy", {31'd0, bus.o_in_ready}, 1);
    mon_en = 1'b1;

    load(1, 1'b0);
    stream(-1, -1, -1, -1);
    check("latency", t_done - t0, 87);

    load(1, 1'b1);
    stream(5, 2, -1, -1);

    load(1, 1'b0);
    stream(-1, -1, 3, 4);

    load(1, 1'b0);
    stream(-1, -1, -1, -1);

    load(2, 1'b0);
    bus2.i_xbar_ready = 1'b1;
    check("deg_last", {31'd0, bus2.o_last_bit}, 1);
    q2.push_back(mk(2'd1, 4'd0, 4'd0, 1'b1));
    tick();
    q2.push_back(mk(2'd3, 4'd0, 4'd0, 1'b0));
    tick();
    check("deg_back_load", {31'd0, bus2.o_in_ready}, 1);

    tick();
    check("q1_empty", q1.size(), 0);
    check("q2_empty", q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
